// File: rtl/seg_display_source_if.sv
// Signal bundle between the seven-segment page source and its environment:
// raw buttons and debug words in, display nibbles and page status out.
interface seg_display_source_if;
  logic        btn_next;
  logic        btn_freeze;
  logic [31:0] src0;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] src3;
  logic [3:0]  anw_0;
  logic [3:0]  anw_1;
  logic [3:0]  anw_2;
  logic [3:0]  anw_3;
  logic [2:0]  page;
  logic        frozen;

  modport master (
    output btn_next, btn_freeze, src0, src1, src2, src3,
    input  anw_0, anw_1, anw_2, anw_3, page, frozen
  );

  modport slave (
    input  btn_next, btn_freeze, src0, src1, src2, src3,
    output anw_0, anw_1, anw_2, anw_3, page, frozen
  );
endinterface

// File: rtl/seg_display_source.sv
// Picks a 16-bit half of one of four CPU debug words for the 4-digit scanner;
// debounced buttons step the page and freeze the displayed value.
module seg_display_source #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter logic [2:0]  INIT_PAGE       = 3'd1
) (
  input logic                 clk,
  input logic                 reset,
  seg_display_source_if.slave bus
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is the next button, bit 1 the freeze button.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q;
  logic [1:0]      sync2_q;
  logic [1:0]      stable_q;
  logic [1:0]      stable_dly_q;
  logic [1:0]      pulse_q;
  logic [CntW-1:0] cnt_q [2];

  logic [2:0]  page_q;
  logic        frozen_q;
  logic [15:0] anw_q;
  logic [31:0] word;
  logic [15:0] half;

  assign btn_raw = {bus.btn_freeze, bus.btn_next};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      pulse_q      <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      stable_dly_q <= stable_q;
      pulse_q      <= stable_q & ~stable_dly_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (cnt_q[i] == CntMax) begin
            stable_q[i] <= sync2_q[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CntW'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    word = '0;
    unique case (page_q[2:1])
      2'd0: word = bus.src0;
      2'd1: word = bus.src1;
      2'd2: word = bus.src2;
      2'd3: word = bus.src3;
    endcase
    half = page_q[0] ? word[15:0] : word[31:16];
  end

  // The load enable uses the registered frozen flag, so a freeze taking effect
  // on the same edge as a page step keeps the pre-step nibbles on display.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      page_q   <= INIT_PAGE;
      frozen_q <= 1'b0;
      anw_q    <= '0;
    end else begin
      if (pulse_q[0]) page_q <= page_q + 3'd1;
      if (pulse_q[1]) frozen_q <= ~frozen_q;
      if (!frozen_q) anw_q <= half;
    end
  end

  assign bus.anw_3  = anw_q[15:12];
  assign bus.anw_2  = anw_q[11:8];
  assign bus.anw_1  = anw_q[7:4];
  assign bus.anw_0  = anw_q[3:0];
  assign bus.page   = page_q;
  assign bus.frozen = frozen_q;

endmodule

// File: tb/tb_seg_display_source.sv
// Scoreboard bench for seg_display_source: stimulus queues expected page/frozen/anw
// values tagged with a cycle number, and a negedge monitor retires them.
module tb_seg_display_source;
  localparam int unsigned D = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic btn_n = 1'b0;
  logic btn_f = 1'b0;
  logic [31:0] src_v [4];

  always #5 clk = ~clk;

  seg_display_source_if bus ();

  assign bus.btn_next   = btn_n;
  assign bus.btn_freeze = btn_f;
  assign bus.src0       = src_v[0];
  assign bus.src1       = src_v[1];
  assign bus.src2       = src_v[2];
  assign bus.src3       = src_v[3];

  seg_display_source #(
    .DEBOUNCE_CYCLES(D),
    .INIT_PAGE      (3'd1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    int          at;
    string       name;
    logic [2:0]  page;
    logic        frozen;
    bit          chk_anw;
    logic [15:0] anw;
  } exp_t;

  exp_t       sb[$];
  int         cyc   = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [2:0] m_page;
  logic       m_frozen;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: retire every expectation whose cycle has come.
  initial begin
    logic [15:0] got;
    forever begin
      @(negedge clk);
      got = {bus.anw_3, bus.anw_2, bus.anw_1, bus.anw_0};
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at <= cyc) begin
          n_cmp++;
          if (bus.page !== sb[i].page || bus.frozen !== sb[i].frozen ||
              (sb[i].chk_anw && got !== sb[i].anw) || sb[i].at != cyc) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got page=%0d frozen=%0b anw=%h, want page=%0d frozen=%0b anw=%h (chk_anw=%0b, due %0d)",
                     sb[i].name, cyc, bus.page, bus.frozen, got, sb[i].page, sb[i].frozen,
                     sb[i].anw, sb[i].chk_anw, sb[i].at);
          end
          sb.delete(i);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int at, input string name, input logic [2:0] p,
                           input logic f, input bit ca, input logic [15:0] a);
    exp_t e;
    e.at = at; e.name = name; e.page = p; e.frozen = f; e.chk_anw = ca; e.anw = a;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] half_of(input logic [2:0] p);
    logic [31:0] w;
    w = src_v[p[2:1]];
    return p[0] ? w[15:0] : w[31:16];
  endfunction

  // One clean press lasting 20 cycles; page/frozen flip exactly D+4 cycles after the press.
  task automatic press(input bit nxt, input bit frz, input int hold);
    int c;
    logic [2:0] p0;
    logic f0;
    c  = cyc;
    p0 = m_page;
    f0 = m_frozen;
    if (nxt) m_page = m_page + 3'd1;
    if (frz) m_frozen = ~m_frozen;
    expect_at(c + D + 3, "press_before", p0, f0, 1'b0, 16'h0);
    expect_at(c + D + 4, "press_after", m_page, m_frozen, 1'b0, 16'h0);
    btn_n = nxt;
    btn_f = frz;
    tick(hold);
    btn_n = 1'b0;
    btn_f = 1'b0;
    tick(20 - hold);
  endtask

  initial begin
    int c;
    logic [2:0] np;
    src_v[0] = 32'h00400010;
    src_v[1] = 32'h33334444;
    src_v[2] = 32'h55556666;
    src_v[3] = 32'h77778888;
    m_page   = 3'd1;
    m_frozen = 1'b0;
    #1 reset = 1'b0;

    // Reset and first load
    tick(2);
    n_cmp++;
    if (bus.page !== 3'd1 || bus.frozen !== 1'b0 ||
        {bus.anw_3, bus.anw_2, bus.anw_1, bus.anw_0} !== 16'h0000) begin
      n_bad++;
      $display("FAIL direct_reset: page=%0d frozen=%0b", bus.page, bus.frozen);
    end
    expect_at(cyc, "reset_state", 3'd1, 1'b0, 1'b1, 16'h0000);
    c = cyc;
    reset = 1'b1;
    expect_at(c, "reset_release_hold", 3'd1, 1'b0, 1'b1, 16'h0000);
    expect_at(c + 1, "reset_first_load", 3'd1, 1'b0, 1'b1, 16'h0010);
    tick(3);

    // Page wrap through all eight pages
    src_v[0] = 32'h11112222;
    tick(2);
    for (int k = 0; k < 8; k++) begin
      np = m_page + 3'd1;
      expect_at(cyc + D + 5, "wrap_anw", np, 1'b0, 1'b1, half_of(np));
      if (np == 3'd4) expect_at(cyc + D + 5, "page4_anw", 3'd4, 1'b0, 1'b1, 16'h5555);
      press(1'b1, 1'b0, 10);
    end

    // Glitches shorter than the debounce window are ignored
    for (int w = 1; w <= int'(D) - 2; w++) begin
      btn_n = 1'b1;
      tick(w);
      btn_n = 1'b0;
      tick(12);
      expect_at(cyc, "glitch_reject", 3'd1, 1'b0, 1'b1, 16'h2222);
      tick(1);
    end
    press(1'b1, 1'b0, 3 * D);
    tick(10);
    n_cmp++;
    if (bus.page !== 3'd2 || {bus.anw_3, bus.anw_2, bus.anw_1, bus.anw_0} !== 16'h3333) begin
      n_bad++;
      $display("FAIL direct_long_hold: page=%0d", bus.page);
    end
    expect_at(cyc, "long_hold_once", 3'd2, 1'b0, 1'b1, 16'h3333);
    tick(1);

    // Freeze on page 0
    src_v[0] = 32'hDEADBEEF;
    while (m_page != 3'd0) press(1'b1, 1'b0, 6);
    expect_at(cyc + D + 5, "freeze_dead", 3'd0, 1'b1, 1'b1, 16'hDEAD);
    press(1'b0, 1'b1, 6);
    src_v[0] = 32'h00000000;
    for (int k = 0; k < 2; k++) begin
      expect_at(cyc + D + 5, "frozen_next", m_page + 3'd1, 1'b1, 1'b1, 16'hDEAD);
      press(1'b1, 1'b0, 6);
    end
    c = cyc;
    expect_at(c + D + 4, "unfreeze_hold", 3'd2, 1'b0, 1'b1, 16'hDEAD);
    expect_at(c + D + 5, "unfreeze_load", 3'd2, 1'b0, 1'b1, 16'h3333);
    press(1'b0, 1'b1, 6);

    // Simultaneous next and freeze from page 3
    expect_at(cyc + D + 5, "page3_anw", 3'd3, 1'b0, 1'b1, 16'h4444);
    press(1'b1, 1'b0, 6);
    c = cyc;
    expect_at(c + D + 5, "simul_keep", 3'd4, 1'b1, 1'b1, 16'h4444);
    expect_at(c + D + 12, "simul_keep_late", 3'd4, 1'b1, 1'b1, 16'h4444);
    press(1'b1, 1'b1, 6);

    // Async reset in the middle of a debounce count, button still held after
    src_v[0] = 32'h00400010;
    btn_n = 1'b1;
    tick(3);
    reset = 1'b0;
    m_page   = 3'd1;
    m_frozen = 1'b0;
    expect_at(cyc, "reset_async", 3'd1, 1'b0, 1'b1, 16'h0000);
    tick(3);
    c = cyc;
    reset = 1'b1;
    expect_at(c + 1, "post_reset_load", 3'd1, 1'b0, 1'b1, 16'h0010);
    expect_at(c + D + 3, "post_reset_pre", 3'd1, 1'b0, 1'b1, 16'h0010);
    expect_at(c + D + 4, "post_reset_post", 3'd2, 1'b0, 1'b0, 16'h0000);
    expect_at(c + D + 5, "post_reset_anw", 3'd2, 1'b0, 1'b1, 16'h3333);
    tick(12);
    btn_n = 1'b0;
    tick(15);
    n_cmp++;
    if (bus.page !== 3'd2 || bus.frozen !== 1'b0 ||
        {bus.anw_3, bus.anw_2, bus.anw_1, bus.anw_0} !== 16'h3333) begin
      n_bad++;
      $display("FAIL direct_post_reset: page=%0d frozen=%0b", bus.page, bus.frozen);
    end
    expect_at(cyc, "post_reset_once", 3'd2, 1'b0, 1'b1, 16'h3333);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
    while (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never checked, due at cyc %0d, now cyc %0d", sb[0].name, sb[0].at, cyc);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
